dco_ad: RTL and testbench

Parametrised add/delete digitally controlled oscillator for the DPLL loop; successor to the fixed-ratio DCO. Divides the system clock by a runtime-programmable ratio N and phase-corrects the output by shortening or lengthening single output periods in response to `add`/`sub` requests from the loop filter. Requests are buffered in a saturating signed pending counter and applied at most one per output period, bounding the jitter each correction introduces. Status outputs expose period boundaries and pending-correction depth for lock detection.

---
 rtl/dco_ad_if.sv | 28 ++
 rtl/dco_ad.sv | 167 ++++++++++++++++
 tb/tb_dco_ad.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dco_ad_if.sv
// Control and status bundle for the add/delete DCO.
// The loop filter side (master) issues add/sub requests and ratio loads.
// The oscillator side (slave) returns the clock, period strobe and correction status.
`timescale 1ns/1ps

interface dco_ad_if #(
  parameter int DIV_W  = 8,
  parameter int PEND_W = 4
);
  logic              add;
  logic              sub;
  logic [DIV_W-1:0]  div_in;
  logic              div_load;
  logic              dco_clk;
  logic              period_start;
  logic [PEND_W-1:0] pend;
  logic              sat;

  modport master (
    output add, sub, div_in, div_load,
    input  dco_clk, period_start, pend, sat
  );

  modport slave (
    input  add, sub, div_in, div_load,
    output dco_clk, period_start, pend, sat
  );
endinterface

// File: rtl/dco_ad.sv
// Add/delete digitally controlled oscillator.
// Divides clk by a programmable ratio N.  Each output period may be shortened
// (N-1) or lengthened (N+1) by one cycle to consume one buffered correction.
// Corrections are queued in a saturating signed counter, one consumed per period.
`timescale 1ns/1ps

module dco_ad #(
  parameter int DIV_W   = 8,
  parameter int DIV_DEF = 16,
  parameter int PEND_W  = 4
) (
  input logic     clk,
  input logic     rst_n,
  dco_ad_if.slave bus
);

  // Phase and period length need one extra bit so an N+1 period at the
  // largest ratio does not wrap.
  localparam int PH_W   = DIV_W + 1;
  // Two guard bits hold pend + net - consume before clamping.
  localparam int SUM_W  = PEND_W + 2;
  localparam int PMAX_I = (1 << (PEND_W - 1)) - 1;

  localparam logic signed [SUM_W-1:0] PMAX_S = SUM_W'(PMAX_I);
  localparam logic signed [SUM_W-1:0] NMAX_S = -SUM_W'(PMAX_I);
  localparam logic [PEND_W-1:0]       PMAX_P = PEND_W'(PMAX_I);
  localparam logic [PEND_W-1:0]       NMAX_P = PEND_W'(-PMAX_I);
  localparam logic [DIV_W-1:0]        DIV_MIN = DIV_W'(4);
  localparam logic [DIV_W-1:0]        DIV_RST = DIV_W'(DIV_DEF);

  // Correction applied to the period that begins at a boundary.
  typedef enum logic [1:0] {
    CORR_NONE,
    CORR_SHORT,
    CORR_LONG
  } corr_e;

  // State registers
  logic [PH_W-1:0]   ph;
  logic [PH_W-1:0]   per_len;
  logic [DIV_W-1:0]  cur_div;
  logic [DIV_W-1:0]  shd_div;
  logic [PEND_W-1:0] pend_q;
  logic              dco_q;
  logic              start_q;
  logic              sat_q;

  // Next-state values
  logic [PH_W-1:0]         ph_next;
  logic [PH_W-1:0]         len_next;
  logic [DIV_W-1:0]        cur_div_next;
  logic [DIV_W-1:0]        shd_div_next;
  logic [PEND_W-1:0]       pend_next;
  logic                    dco_next;
  logic                    start_next;
  logic                    sat_next;
  logic                    boundary;
  corr_e                   corr;
  logic signed [SUM_W-1:0] pend_ext;
  logic signed [SUM_W-1:0] net;
  logic signed [SUM_W-1:0] consume;
  logic signed [SUM_W-1:0] sum;

  assign boundary = (ph == per_len - PH_W'(1));
  assign pend_ext = {{2{pend_q[PEND_W-1]}}, pend_q};

  // Decide which correction the next period carries, from the pre-edge pend.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    corr = CORR_NONE;
    if (pend_q[PEND_W-1]) begin
      corr = CORR_LONG;
    end else if (pend_q != '0) begin
      corr = CORR_SHORT;
    end
  end

  // Phase counter, period length and ratio hand-over at each boundary.
  always_comb begin
    ph_next      = ph + PH_W'(1);
    len_next     = per_len;
    cur_div_next = cur_div;
    consume      = '0;
    if (boundary) begin
      ph_next      = '0;
      cur_div_next = shd_div;
      unique case (corr)
        CORR_SHORT: begin
          len_next = {1'b0, shd_div} - PH_W'(1);
          consume  = SUM_W'(1);
        end
        CORR_LONG: begin
          len_next = {1'b0, shd_div} + PH_W'(1);
          consume  = -SUM_W'(1);
        end
        default: begin
          len_next = {1'b0, shd_div};
        end
      endcase
    end
  end

  // Net request this cycle, then saturating update of the pending counter.
  always_comb begin
    net = '0;
    if (bus.add && !bus.sub) begin
      net = SUM_W'(1);
    end else if (bus.sub && !bus.add) begin
      net = -SUM_W'(1);
    end
    sum       = pend_ext + net - consume;
    pend_next = sum[PEND_W-1:0];
    if (sum > PMAX_S) begin
      pend_next = PMAX_P;
    end else if (sum < NMAX_S) begin
      pend_next = NMAX_P;
    end
    sat_next = (pend_next == PMAX_P) || (pend_next == NMAX_P);
  end

  // Shadow ratio load with a floor of 4 so a period never drops below 3 cycles.
  always_comb begin
    shd_div_next = shd_div;
    if (bus.div_load) begin
      shd_div_next = (bus.div_in < DIV_MIN) ? DIV_MIN : bus.div_in;
    end
  end

  // Output decode from next-state values so the outputs come straight off flops.
  always_comb begin
    dco_next   = (ph_next < {1'b0, 1'b0, cur_div_next[DIV_W-1:1]});
    start_next = (ph_next == '0);
  end

  // State and output registers.  Reset parks ph one cycle before the end of a
  // DIV_DEF period so the first edge after release is a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= PH_W'(DIV_DEF - 1);
      per_len <= PH_W'(DIV_DEF);
      cur_div <= DIV_RST;
      shd_div <= DIV_RST;
      pend_q  <= '0;
      dco_q   <= 1'b0;
      start_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      ph      <= ph_next;
      per_len <= len_next;
      cur_div <= cur_div_next;
      shd_div <= shd_div_next;
      pend_q  <= pend_next;
      dco_q   <= dco_next;
      start_q <= start_next;
      sat_q   <= sat_next;
    end
  end

  assign bus.dco_clk      = dco_q;
  assign bus.period_start = start_q;
  assign bus.pend         = pend_q;
  assign bus.sat          = sat_q;

endmodule

// File: tb/tb_dco_ad.sv
// Bench for dco_ad: expected period shapes (length, high cycles) are queued
// as stimulus is applied; a monitor measures each completed period and pops
// the matching expectation.  Pending-counter values are checked inline.
`timescale 1ns/1ps

module tb_dco_ad;
  localparam int DIV_W   = 8;
  localparam int DIV_DEF = 16;
  localparam int PEND_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dco_ad_if #(.DIV_W(DIV_W), .PEND_W(PEND_W)) bus ();

  dco_ad #(.DIV_W(DIV_W), .DIV_DEF(DIV_DEF), .PEND_W(PEND_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int len;
    int high;
  } period_t;

  period_t exp_q[$];
  int      n_tests   = 0;
  int      n_fail    = 0;
  int      n_done    = 0;
  int      tb_ph     = 0;
  int      mon_len   = 0;
  int      mon_high  = 0;
  bit      have_prev = 1'b0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int len, input int high, input int count);
    period_t e;
    e.len  = len;
    e.high = high;
    for (int i = 0; i < count; i++) exp_q.push_back(e);
  endtask

  // Period monitor: samples 2 ns after each rising edge.
  always @(posedge clk) begin : monitor
    period_t e;
    #2;
    if (!rst_n) begin
      have_prev = 1'b0;
      tb_ph     = 0;
    end else if (bus.period_start) begin
      if (have_prev) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("period_unexpected", mon_len, -1);
        end else begin
          e = exp_q.pop_front();
          check("period_len", mon_len, e.len);
          check("period_high", mon_high, e.high);
        end
      end
      have_prev = 1'b1;
      mon_len   = 1;
      mon_high  = int'(bus.dco_clk);
      tb_ph     = 0;
    end else begin
      mon_len++;
      mon_high += int'(bus.dco_clk);
      tb_ph++;
    end
  end

  task automatic wait_ph(input int k);
    int n = 0;
    while (tb_ph != k && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (tb_ph != k) check("wait_ph_timeout", tb_ph, k);
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (n_done < k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n_done < k) check("wait_done_timeout", n_done, k);
  endtask

  task automatic pulse(input bit is_add);
    if (is_add) bus.add = 1'b1;
    else        bus.sub = 1'b1;
    @(negedge clk);
    bus.add = 1'b0;
    bus.sub = 1'b0;
  endtask

  task automatic load_div(input int val);
    bus.div_in   = DIV_W'(val);
    bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_done=%0d", n_done);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.add      = 1'b0;
    bus.sub      = 1'b0;
    bus.div_in   = '0;
    bus.div_load = 1'b0;

    // Reset state
    #7;
    check("rst_dco_clk", bus.dco_clk, 0);
    check("rst_period_start", bus.period_start, 0);
    check("rst_pend", $signed(bus.pend), 0);
    check("rst_sat", bus.sat, 0);
    repeat (2) @(negedge clk);

    // Idle: 12 plain 16-cycle periods
    push_exp(16, 8, 12);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_start", bus.period_start, 1);
    check("first_edge_dco", bus.dco_clk, 1);
    wait_done(12);
    check("idle_pend", $signed(bus.pend), 0);
    check("idle_sat", bus.sat, 0);

    // Single add at ph=5 shortens the following period only
    push_exp(16, 8, 1);
    push_exp(15, 8, 1);
    wait_ph(5);
    pulse(1'b1);
    check("add1_pend", $signed(bus.pend), 1);
    wait_done(13);
    check("add1_consumed", $signed(bus.pend), 0);

    // Three sub pulses give three consecutive 17-cycle periods
    push_exp(16, 8, 1);
    wait_done(14);
    push_exp(17, 8, 3);
    wait_ph(2); pulse(1'b0);
    wait_ph(4); pulse(1'b0);
    wait_ph(6); pulse(1'b0);
    check("sub3_pend", $signed(bus.pend), -3);
    wait_done(18);
    check("sub3_drained", $signed(bus.pend), 0);

    // add held 20 cycles: saturates at 7; 8 requests accepted -> 8 short periods
    push_exp(16, 8, 1);
    push_exp(15, 8, 8);
    bus.add = 1'b1;
    repeat (20) @(negedge clk);
    bus.add = 1'b0;
    check("hold_pend", $signed(bus.pend), 7);
    check("hold_sat", bus.sat, 1);
    wait_done(27);
    check("hold_drained_pend", $signed(bus.pend), 0);
    check("hold_drained_sat", bus.sat, 0);

    // Alternating add/sub, then simultaneous add&sub: all 16-cycle periods
    push_exp(16, 8, 11);
    wait_ph(1);
    for (int k = 0; k < 150; k++) begin
      bus.add = (k < 100) ? (k % 2 == 0) : 1'b1;
      bus.sub = (k < 100) ? (k % 2 == 1) : 1'b1;
      @(negedge clk);
      check("alt_pend", $signed(bus.pend), (k < 100 && k % 2 == 0) ? 1 : 0);
    end
    bus.add = 1'b0;
    bus.sub = 1'b0;
    check("alt_sat", bus.sat, 0);
    wait_done(38);

    // Ratio change to 10 mid-period: current period untouched
    push_exp(16, 8, 1);
    push_exp(10, 5, 2);
    wait_ph(3);
    load_div(10);
    wait_done(40);

    // Ratio 2 clamps to 4
    push_exp(4, 2, 1);
    wait_ph(2);
    load_div(2);
    wait_done(42);

    // Ratio 255 with a pending retard -> 256-cycle period, no wrap
    push_exp(4, 2, 1);
    push_exp(256, 127, 1);
    push_exp(255, 127, 1);
    bus.div_in   = DIV_W'(255);
    bus.div_load = 1'b1;
    bus.sub      = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.sub      = 1'b0;
    check("big_pend", $signed(bus.pend), -1);
    wait_done(43);
    check("big_consumed", $signed(bus.pend), 0);
    wait_done(44);
    load_div(16);
    wait_done(45);

    // Asynchronous reset mid-period with pend=3
    wait_ph(1);
    bus.add = 1'b1;
    repeat (3) @(negedge clk);
    bus.add = 1'b0;
    check("pre_rst_pend", $signed(bus.pend), 3);
    wait_ph(9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dco_clk", bus.dco_clk, 0);
    check("async_rst_period_start", bus.period_start, 0);
    check("async_rst_pend", $signed(bus.pend), 0);
    check("async_rst_sat", bus.sat, 0);
    repeat (3) @(negedge clk);
    base = n_done;
    push_exp(16, 8, 3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_start", bus.period_start, 1);
    check("rerst_dco", bus.dco_clk, 1);
    wait_done(base + 3);

    check("exp_q_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
